// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline stall/flush controller:
// MUL sequencer state encoding, default parameters, the register-zero address
// and a helper that derives the MUL down-counter start value.
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    // MUL sequencer states.
    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    localparam int MUL_LAT_DEF = 4;   // cycles a MUL occupies EX
    localparam int CNT_W_DEF   = 32;  // performance counter width
    localparam int MUL_CNT_W   = 4;   // width of the MUL down-counter

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Start value of the MUL down-counter. The first stall cycle is spent in
    // IDLE, so MUL_BUSY only needs MUL_LAT-2 more stall cycles before release.
    // Latencies of 1 never enter MUL_BUSY; return 0 so the value stays legal.
    function automatic logic [MUL_CNT_W-1:0] mul_cnt_init(input int lat);
        if (lat > 1) begin
            return MUL_CNT_W'(lat - 2);
        end
        return '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for pipeline performance statistics.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset, clears the count
//   inc_i    in   increment request (ignored once at all-ones)
//   clr_i    in   synchronous clear, wins over inc_i
//   count_o  out  current count, CNT_W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // NOTE: every signal written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush controller for the 5-stage MIPS pipeline.
//   - Holds ID/EX (and bubbles EX/MEM) while a multi-cycle MUL occupies EX.
//   - Inserts a one-cycle bubble into ID/EX on a load-use hazard.
//   - Flushes IF/ID when a taken branch in ID actually advances.
//   - Counts stalled cycles and load-use bubbles (saturating).
// Priority of the three causes: MUL stall > load-use > branch flush.
//
// Ports:
//   clk              in   pipeline clock
//   rst              in   asynchronous active-low reset (0 = reset)
//   id_valid         in   ID holds a valid instruction
//   id_rs_addr       in   rs of the ID instruction (5)
//   id_rt_addr       in   rt of the ID instruction (5)
//   id_uses_rs       in   ID instruction reads rs
//   id_uses_rt       in   ID instruction reads rt
//   id_branch_taken  in   branch/jump in ID resolved taken
//   ex_is_lw         in   is_lw from ID/EX
//   ex_write         in   write from ID/EX
//   ex_w_addr        in   w_addr from ID/EX (5)
//   ex_is_mul        in   is_mul from ID/EX
//   perf_clr         in   synchronous clear of the performance counters
//   pc_stall         out  hold PC
//   if_id_stall      out  hold IF/ID
//   if_id_flush      out  clear IF/ID next edge
//   id_ex_hold       out  hold ID/EX contents
//   id_ex_bubble     out  load NOP into ID/EX next edge
//   ex_mem_bubble    out  load NOP into EX/MEM next edge
//   mul_busy         out  sequencer is in MUL_BUSY
//   stall_cycles     out  cycles with pc_stall=1 (CNT_W)
//   load_use_cnt     out  load-use bubbles inserted (CNT_W)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch_taken,
    input  logic             ex_is_lw,
    input  logic             ex_write,
    input  logic [4:0]       ex_w_addr,
    input  logic             ex_is_mul,
    input  logic             perf_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] load_use_cnt
);

    localparam logic                 MUL_STALLS = (MUL_LAT > 1);
    localparam logic [MUL_CNT_W-1:0] CNT_INIT   = mul_cnt_init(MUL_LAT);

    state_e               state_q, state_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

    logic mul_stall_raw;
    logic mul_stall;
    logic lu_raw;
    logic lu;
    logic stall_any;

    // -------------------------------------------------------------------------
    // MUL sequencer: the IDLE cycle that sees the MUL is the first stall
    // cycle; MUL_BUSY counts down the rest and spends its cnt==0 cycle
    // releasing ID/EX, so the same MUL is never seen again from IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mul_stall_raw = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_is_mul && MUL_STALLS) begin
                    mul_stall_raw = 1'b1;
                    state_d       = MUL_BUSY;
                    cnt_d         = CNT_INIT;
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    mul_stall_raw = 1'b1;
                    cnt_d         = cnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Load-use hazard: the lw in EX produces its data only after MEM, so a
    // dependent instruction in ID must wait one cycle. $0 is never a hazard.
    // -------------------------------------------------------------------------
    always_comb begin
        lu_raw = id_valid && ex_is_lw && ex_write && (ex_w_addr != REG_ZERO) &&
                 ((id_uses_rs && (id_rs_addr == ex_w_addr)) ||
                  (id_uses_rt && (id_rt_addr == ex_w_addr)));
    end

    // Reset gates every control output low, even while inputs request a stall.
    assign mul_stall = mul_stall_raw && rst;
    assign lu        = lu_raw && rst;
    assign stall_any = mul_stall || lu;

    assign pc_stall      = stall_any;
    assign if_id_stall   = stall_any;
    assign id_ex_hold    = mul_stall;
    assign ex_mem_bubble = mul_stall;
    // While the MUL holds ID/EX the lw cannot be in EX, so the bubble yields.
    assign id_ex_bubble  = lu && !mul_stall;
    // A stalled branch keeps its fetch slot; flush only when it advances.
    assign if_id_flush   = id_branch_taken && rst && !stall_any;
    assign mul_busy      = (state_q == MUL_BUSY) && rst;

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (pc_stall),
        .clr_i   (perf_clr),
        .count_o (stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_lu_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (id_ex_bubble),
        .clr_i   (perf_clr),
        .count_o (load_use_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Three instances share one stimulus:
//   u_dut4 : MUL_LAT=4, CNT_W=32  (main instance)
//   u_dut2 : MUL_LAT=2, CNT_W=2   (back-to-back MULs, counter saturation)
//   u_dut1 : MUL_LAT=1, CNT_W=32  (MUL never stalls)
// Control vectors are packed as
//   {pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_bubble,
//    ex_mem_bubble, mul_busy}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_branch_taken;
    logic       ex_is_lw;
    logic       ex_write;
    logic [4:0] ex_w_addr;
    logic       ex_is_mul;
    logic       perf_clr;

    logic        pc_stall4, if_id_stall4, if_id_flush4, id_ex_hold4;
    logic        id_ex_bubble4, ex_mem_bubble4, mul_busy4;
    logic [31:0] sc4, lu4;
    logic        pc_stall2, if_id_stall2, if_id_flush2, id_ex_hold2;
    logic        id_ex_bubble2, ex_mem_bubble2, mul_busy2;
    logic [1:0]  sc2, lu2;
    logic        pc_stall1, if_id_stall1, if_id_flush1, id_ex_hold1;
    logic        id_ex_bubble1, ex_mem_bubble1, mul_busy1;
    logic [31:0] sc1, lu1;

    logic [6:0] v4, v2, v1;
    assign v4 = {pc_stall4, if_id_stall4, if_id_flush4, id_ex_hold4,
                 id_ex_bubble4, ex_mem_bubble4, mul_busy4};
    assign v2 = {pc_stall2, if_id_stall2, if_id_flush2, id_ex_hold2,
                 id_ex_bubble2, ex_mem_bubble2, mul_busy2};
    assign v1 = {pc_stall1, if_id_stall1, if_id_flush1, id_ex_hold1,
                 id_ex_bubble1, ex_mem_bubble1, mul_busy1};

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) u_dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_is_lw(ex_is_lw), .ex_write(ex_write),
        .ex_w_addr(ex_w_addr), .ex_is_mul(ex_is_mul), .perf_clr(perf_clr),
        .pc_stall(pc_stall4), .if_id_stall(if_id_stall4), .if_id_flush(if_id_flush4),
        .id_ex_hold(id_ex_hold4), .id_ex_bubble(id_ex_bubble4),
        .ex_mem_bubble(ex_mem_bubble4), .mul_busy(mul_busy4),
        .stall_cycles(sc4), .load_use_cnt(lu4)
    );

    pipe_hazard_ctrl #(.MUL_LAT(2), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_is_lw(ex_is_lw), .ex_write(ex_write),
        .ex_w_addr(ex_w_addr), .ex_is_mul(ex_is_mul), .perf_clr(perf_clr),
        .pc_stall(pc_stall2), .if_id_stall(if_id_stall2), .if_id_flush(if_id_flush2),
        .id_ex_hold(id_ex_hold2), .id_ex_bubble(id_ex_bubble2),
        .ex_mem_bubble(ex_mem_bubble2), .mul_busy(mul_busy2),
        .stall_cycles(sc2), .load_use_cnt(lu2)
    );

    pipe_hazard_ctrl #(.MUL_LAT(1), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
        .id_rt_addr(id_rt_addr), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_branch_taken(id_branch_taken), .ex_is_lw(ex_is_lw), .ex_write(ex_write),
        .ex_w_addr(ex_w_addr), .ex_is_mul(ex_is_mul), .perf_clr(perf_clr),
        .pc_stall(pc_stall1), .if_id_stall(if_id_stall1), .if_id_flush(if_id_flush1),
        .id_ex_hold(id_ex_hold1), .id_ex_bubble(id_ex_bubble1),
        .ex_mem_bubble(ex_mem_bubble1), .mul_busy(mul_busy1),
        .stall_cycles(sc1), .load_use_cnt(lu1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Structural rules that must hold on every instance in every cycle.
    task automatic check_rules();
        check("rule_hold_bubble4", {31'd0, id_ex_hold4 & id_ex_bubble4}, 32'd0);
        check("rule_stall_flush4", {31'd0, if_id_stall4 & if_id_flush4}, 32'd0);
        check("rule_hold_bubble2", {31'd0, id_ex_hold2 & id_ex_bubble2}, 32'd0);
        check("rule_stall_flush2", {31'd0, if_id_stall2 & if_id_flush2}, 32'd0);
        check("rule_stall_flush1", {31'd0, if_id_stall1 & if_id_flush1}, 32'd0);
    endtask

    // Inputs are changed 1 ns after the rising edge and sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        check_rules();
    endtask

    task automatic clear_inputs();
        id_valid        = 1'b0;
        id_rs_addr      = 5'd0;
        id_rt_addr      = 5'd0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_branch_taken = 1'b0;
        ex_is_lw        = 1'b0;
        ex_write        = 1'b0;
        ex_w_addr       = 5'd0;
        ex_is_mul       = 1'b0;
        perf_clr        = 1'b0;
    endtask

    task automatic set_lw(input logic [4:0] w);
        ex_is_lw  = 1'b1;
        ex_write  = 1'b1;
        ex_w_addr = w;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_s4, exp_b4, exp_s2;
        logic [2:0] exp_h4;

        // ---------------- Reset with every stall cause asserted -------------
        rst = 1'b0;
        clear_inputs();
        ex_is_mul       = 1'b1;
        set_lw(5'd5);
        id_valid        = 1'b1;
        id_rs_addr      = 5'd5;
        id_uses_rs      = 1'b1;
        id_branch_taken = 1'b1;
        tick();
        tick();
        settle();
        check("rst_vec4", {25'd0, v4}, 32'd0);
        check("rst_vec2", {25'd0, v2}, 32'd0);
        check("rst_vec1", {25'd0, v1}, 32'd0);
        check("rst_sc4", sc4, 32'd0);
        check("rst_lu4", lu4, 32'd0);

        // Release: IDLE sees the MUL immediately.
        tick();
        rst = 1'b1;
        settle();
        check("rel_vec4", {25'd0, v4}, {25'd0, 7'b1101010});
        check("rel_vec1", {25'd0, v1}, {25'd0, 7'b1100100});
        tick();
        settle();
        check("busy_vec4", {25'd0, v4}, {25'd0, 7'b1101011});
        check("busy_sc4", sc4, 32'd1);

        // Reset in the middle of the MUL aborts everything at once.
        rst = 1'b0;
        #1;
        check("abort_vec4", {25'd0, v4}, 32'd0);
        check("abort_sc4", sc4, 32'd0);
        clear_inputs();
        tick();
        rst = 1'b1;
        settle();
        check("post_abort_vec4", {25'd0, v4}, 32'd0);
        check("post_abort_vec2", {25'd0, v2}, 32'd0);
        tick();

        // ---------------- One MUL held in EX for 4 cycles -------------------
        // bit i = cycle t+i
        exp_s4 = 4'b0111;
        exp_b4 = 4'b1110;
        exp_s2 = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            ex_is_mul = 1'b1;
            settle();
            check($sformatf("mul_stall4_t%0d", i), {31'd0, pc_stall4}, {31'd0, exp_s4[i]});
            check($sformatf("mul_hold4_t%0d", i), {31'd0, id_ex_hold4}, {31'd0, exp_s4[i]});
            check($sformatf("mul_exmem4_t%0d", i), {31'd0, ex_mem_bubble4}, {31'd0, exp_s4[i]});
            check($sformatf("mul_busy4_t%0d", i), {31'd0, mul_busy4}, {31'd0, exp_b4[i]});
            check($sformatf("mul_stall2_t%0d", i), {31'd0, pc_stall2}, {31'd0, exp_s2[i]});
            check($sformatf("mul_stall1_t%0d", i), {31'd0, pc_stall1}, 32'd0);
            tick();
        end
        ex_is_mul = 1'b0;
        settle();
        check("mul_done_busy4", {31'd0, mul_busy4}, 32'd0);
        check("mul_sc4", sc4, 32'd3);
        check("mul_sc2", {30'd0, sc2}, 32'd2);
        check("mul_sc1", sc1, 32'd0);
        tick();

        // ---------------- Load-use hazards -----------------------------------
        // lw $5 in EX, ID reads rs=5.
        set_lw(5'd5);
        id_valid   = 1'b1;
        id_rs_addr = 5'd5;
        id_uses_rs = 1'b1;
        settle();
        check("lu_rs_vec4", {25'd0, v4}, {25'd0, 7'b1100100});
        tick();
        // lw has moved on, bubble now in EX.
        ex_is_lw = 1'b0;
        settle();
        check("lu_gone_vec4", {25'd0, v4}, 32'd0);
        check("lu_cnt4_a", lu4, 32'd1);
        check("lu_sc4_a", sc4, 32'd4);
        tick();
        // Write to $0 never stalls.
        set_lw(5'd0);
        id_rs_addr = 5'd0;
        settle();
        check("lu_r0_vec4", {25'd0, v4}, 32'd0);
        tick();
        // Match through rt.
        set_lw(5'd7);
        id_rs_addr = 5'd3;
        id_rt_addr = 5'd7;
        id_uses_rt = 1'b1;
        settle();
        check("lu_rt_bubble4", {31'd0, id_ex_bubble4}, 32'd1);
        tick();
        // rt matches but is not read.
        id_uses_rt = 1'b0;
        settle();
        check("lu_rt_unused_vec4", {25'd0, v4}, 32'd0);
        tick();
        // ID slot invalid.
        id_uses_rt = 1'b1;
        id_valid   = 1'b0;
        settle();
        check("lu_id_invalid_vec4", {25'd0, v4}, 32'd0);
        tick();

        // ---------------- Branch vs load-use ---------------------------------
        clear_inputs();
        set_lw(5'd5);
        id_valid        = 1'b1;
        id_rs_addr      = 5'd5;
        id_uses_rs      = 1'b1;
        id_branch_taken = 1'b1;
        settle();
        check("br_lu_vec4", {25'd0, v4}, {25'd0, 7'b1100100});
        tick();
        ex_is_lw = 1'b0;
        settle();
        check("br_adv_vec4", {25'd0, v4}, {25'd0, 7'b0010000});
        check("br_lu_cnt4", lu4, 32'd3);
        check("br_sc4", sc4, 32'd6);
        check("br_sc1", sc1, 32'd3);
        check("br_lu1", lu1, 32'd3);
        tick();
        // Branch while a MUL enters EX: MUL stall wins (except MUL_LAT=1).
        ex_is_mul = 1'b1;
        settle();
        check("br_mul_vec4", {25'd0, v4}, {25'd0, 7'b1101010});
        check("br_mul_vec1", {25'd0, v1}, {25'd0, 7'b0010000});
        tick();
        id_branch_taken = 1'b0;
        exp_h4 = 3'b011;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("br_mul_stall4_%0d", i), {31'd0, pc_stall4}, {31'd0, exp_h4[i]});
            check($sformatf("br_mul_busy4_%0d", i), {31'd0, mul_busy4}, 32'd1);
            tick();
        end

        // ---------------- Saturation and clear -------------------------------
        clear_inputs();
        set_lw(5'd5);
        id_valid   = 1'b1;
        id_rs_addr = 5'd5;
        id_uses_rs = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("sat_bubble2_%0d", i), {31'd0, id_ex_bubble2}, 32'd1);
            tick();
        end
        perf_clr = 1'b1;
        settle();
        check("sat_sc2", {30'd0, sc2}, 32'd3);
        check("sat_lu2", {30'd0, lu2}, 32'd3);
        check("pre_clr_sc4", sc4, 32'd13);
        check("pre_clr_lu4", lu4, 32'd7);
        check("pre_clr_sc1", sc1, 32'd7);
        tick();
        clear_inputs();
        settle();
        check("clr_sc4", sc4, 32'd0);
        check("clr_lu4", lu4, 32'd0);
        check("clr_sc2", {30'd0, sc2}, 32'd0);
        check("clr_lu2", {30'd0, lu2}, 32'd0);
        check("clr_sc1", sc1, 32'd0);
        check("clr_lu1", lu1, 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
